contador_syn_counter: RTL and testbench
=======================================

CONTADOR_SYN_COUNTER -- requirements
Module: contador_syn

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  reset, asynchronous and active-high.
REQ-004 ENABLE  input  1  count/load enable, active-high.
REQ-005 MODO  input  2  operating mode select.
REQ-006 D  input  4  parallel load data.
REQ-007 Q  output  4  registered counter value.
REQ-008 RCO  output  1  registered ripple-carry/borrow-out flag.
REQ-009 LOAD  output  1  registered load-acknowledge flag.

Function
REQ-010 All outputs (Q, RCO, LOAD) SHALL be driven directly from flip-flops, with no combinational path from inputs to outputs.
REQ-011 With ENABLE=0 on a rising edge, Q SHALL hold its value and RCO and LOAD SHALL be 0.
REQ-012 MODO=00 with ENABLE=1: Q SHALL become (Q+1) mod 16.
REQ-013 MODO=01 with ENABLE=1: Q SHALL become (Q-1) mod 16.
REQ-014 MODO=10 with ENABLE=1: Q SHALL become (Q-3) mod 16.
REQ-015 MODO=11 with ENABLE=1: Q SHALL become D, and LOAD SHALL be 1 for that cycle.
REQ-016 LOAD SHALL be 0 after every rising edge that is not an enabled MODO=11 edge.
REQ-017 RCO SHALL be 1 for exactly the cycle following an edge on which Q wrapped.
  - MODO=00: Q was 15, becomes 0.
  - MODO=01: Q was 0, becomes 15.
  - MODO=10: Q was 0, 1 or 2, becomes 13, 14 or 15.
REQ-018 RCO SHALL be 0 after every other edge, including all MODO=11 edges.
REQ-019 Continuous counting across a wrap SHALL neither skip nor repeat values; e.g. MODO=00 gives …,14,15,0,1,…
REQ-020 A mode change between edges SHALL take effect on the next enabled edge, with no idle cycle.
REQ-021 D SHALL be sampled only on enabled MODO=11 edges; D changes at other times SHALL have no effect.
REQ-022 A load SHALL never assert RCO, including when D=0 or D=15.

Reset
REQ-023 While RESET=1, Q, RCO and LOAD SHALL be forced to 0 immediately, independent of clk.
REQ-024 RESET SHALL override ENABLE, MODO and D.
REQ-025 RESET asserted mid-operation SHALL discard the in-progress count or load; no RCO or LOAD pulse SHALL appear after the reset.
REQ-026 On the first rising edge after RESET deasserts, normal operation SHALL resume from Q=0.
  - For example, an enabled MODO=00 edge then gives Q=1.

Verification
REQ-027 Reset: assert RESET between edges with Q=9 and ENABLE=1 -> Q=0, RCO=0, LOAD=0 before the next clk edge; values stay 0 while RESET=1.
REQ-028 Up-count: from reset, ENABLE=1, MODO=00 for 17 edges -> Q=1,2,…,15,0,1; RCO=1 only in the cycle where Q=0.
REQ-029 Down-count: from Q=2, MODO=01 for 4 edges -> Q=1,0,15,14; RCO=1 only in the cycle where Q=15.
REQ-030 Down-by-3: from Q=7, MODO=10 for 4 edges -> Q=4,1,14,11; RCO=1 only in the cycle where Q=14.
REQ-031 Load: MODO=11, D=0xA -> Q=10, LOAD=1, RCO=0 for one cycle; then MODO=00 -> Q=11, LOAD=0.
REQ-032 Hold: ENABLE=0 for 5 edges with Q=6 while MODO and D are randomized -> Q stays 6, RCO=0, LOAD=0.
REQ-033 Random stress: 100 cycles of random ENABLE, MODO and D, with occasional RESET -> outputs match a cycle-accurate reference model of REQ-011 to REQ-026 on every edge.

Source files
------------

// File: rtl/contador_syn_counter.sv
// 4-bit synchronous up/down/down-by-3/load counter with registered
// ripple-carry/borrow flag and registered load-acknowledge flag.
module contador_syn_counter (
   input  logic       clk,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic [1:0] MODO,
   input  logic [3:0] D,
   output logic [3:0] Q,
   output logic       RCO,
   output logic       LOAD
);

   localparam logic [1:0] ModeUp    = 2'b00;
   localparam logic [1:0] ModeDown  = 2'b01;
   localparam logic [1:0] ModeDown3 = 2'b10;
   localparam logic [1:0] ModeLoad  = 2'b11;

   logic [3:0] q_d;
   logic       rco_d;
   logic       load_d;

   // Next-state: count/load on enabled edges; flags are single-cycle pulses.
   always_comb begin
      q_d    = Q;
      rco_d  = 1'b0;
      load_d = 1'b0;
      if (ENABLE) begin
         unique case (MODO)
            ModeUp: begin
               q_d   = Q + 4'd1;
               rco_d = (Q == 4'd15);
            end
            ModeDown: begin
               q_d   = Q - 4'd1;
               rco_d = (Q == 4'd0);
            end
            ModeDown3: begin
               q_d   = Q - 4'd3;
               // Borrow whenever the subtraction crosses zero (Q = 0, 1 or 2).
               rco_d = (Q < 4'd3);
            end
            ModeLoad: begin
               q_d    = D;
               load_d = 1'b1;
            end
            default: begin
               q_d = Q;
            end
         endcase
      end
   end

   // State and output registers; reset clears everything regardless of clk.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         Q    <= 4'd0;
         RCO  <= 1'b0;
         LOAD <= 1'b0;
      end else begin
         Q    <= q_d;
         RCO  <= rco_d;
         LOAD <= load_d;
      end
   end

endmodule

// File: tb/tb_contador_syn_counter.sv
// Directed self-checking bench for contador_syn_counter.
module tb_contador_syn_counter;

   logic       clk;
   logic       RESET;
   logic       ENABLE;
   logic [1:0] MODO;
   logic [3:0] D;
   logic [3:0] Q;
   logic       RCO;
   logic       LOAD;

   int n_cmp;
   int n_err;

   contador_syn_counter dut (
      .clk    (clk),
      .RESET  (RESET),
      .ENABLE (ENABLE),
      .MODO   (MODO),
      .D      (D),
      .Q      (Q),
      .RCO    (RCO),
      .LOAD   (LOAD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      RESET  = 1'b1;
      ENABLE = 1'b0;
      MODO   = 2'b00;
      D      = 4'd0;
      #2;
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_initial: got q=%0d rco=%0b load=%0b, expected q=0 rco=0 load=0",
                  Q, RCO, LOAD);
      end
      tick();
      RESET  = 1'b0;
      ENABLE = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      n_cmp++;
      if (Q !== 4'd9) begin
         n_err++;
         $display("FAIL reset_precount: got q=%0d, expected q=9", Q);
      end
      // Assert reset between edges with the counter running.
      RESET = 1'b1;
      #1;
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_async: got q=%0d rco=%0b load=%0b, expected q=0 rco=0 load=0",
                  Q, RCO, LOAD);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if ({Q, RCO, LOAD} !== {4'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_held[%0d]: got q=%0d rco=%0b load=%0b, expected q=0 rco=0 load=0",
                     i, Q, RCO, LOAD);
         end
      end
      RESET = 1'b0;
   endtask

   task automatic test_up_count();
      logic [3:0] exp_q [17];
      logic       exp_r [17];
      exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
                4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
      exp_r = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      ENABLE = 1'b1;
      MODO   = 2'b00;
      for (int i = 0; i < 17; i++) begin
         tick();
         n_cmp++;
         if ({Q, RCO, LOAD} !== {exp_q[i], exp_r[i], 1'b0}) begin
            n_err++;
            $display("FAIL up[%0d]: got q=%0d rco=%0b load=%0b, expected q=%0d rco=%0b load=0",
                     i, Q, RCO, LOAD, exp_q[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_down_count();
      logic [3:0] exp_q [4];
      logic       exp_r [4];
      exp_q = '{4'd1, 4'd0, 4'd15, 4'd14};
      exp_r = '{0, 0, 1, 0};
      ENABLE = 1'b1;
      MODO   = 2'b11;
      D      = 4'd2;
      tick();
      MODO = 2'b01;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({Q, RCO, LOAD} !== {exp_q[i], exp_r[i], 1'b0}) begin
            n_err++;
            $display("FAIL down[%0d]: got q=%0d rco=%0b load=%0b, expected q=%0d rco=%0b load=0",
                     i, Q, RCO, LOAD, exp_q[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_down3_count();
      logic [3:0] exp_q [4];
      logic       exp_r [4];
      exp_q = '{4'd4, 4'd1, 4'd14, 4'd11};
      exp_r = '{0, 0, 1, 0};
      ENABLE = 1'b1;
      MODO   = 2'b11;
      D      = 4'd7;
      tick();
      MODO = 2'b10;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({Q, RCO, LOAD} !== {exp_q[i], exp_r[i], 1'b0}) begin
            n_err++;
            $display("FAIL down3[%0d]: got q=%0d rco=%0b load=%0b, expected q=%0d rco=%0b load=0",
                     i, Q, RCO, LOAD, exp_q[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_load();
      ENABLE = 1'b1;
      MODO   = 2'b11;
      D      = 4'hA;
      tick();
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd10, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL load_a: got q=%0d rco=%0b load=%0b, expected q=10 rco=0 load=1",
                  Q, RCO, LOAD);
      end
      MODO = 2'b00;
      D    = 4'h3;
      tick();
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd11, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL load_then_up: got q=%0d rco=%0b load=%0b, expected q=11 rco=0 load=0",
                  Q, RCO, LOAD);
      end
      // Loads of the extreme values must not look like a wrap.
      MODO = 2'b11;
      D    = 4'd15;
      tick();
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd15, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL load_f: got q=%0d rco=%0b load=%0b, expected q=15 rco=0 load=1",
                  Q, RCO, LOAD);
      end
      D = 4'd0;
      tick();
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL load_0: got q=%0d rco=%0b load=%0b, expected q=0 rco=0 load=1",
                  Q, RCO, LOAD);
      end
   endtask

   task automatic test_hold();
      ENABLE = 1'b1;
      MODO   = 2'b11;
      D      = 4'd6;
      tick();
      ENABLE = 1'b0;
      for (int i = 0; i < 5; i++) begin
         MODO = 2'($urandom_range(0, 3));
         D    = 4'($urandom_range(0, 15));
         tick();
         n_cmp++;
         if ({Q, RCO, LOAD} !== {4'd6, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL hold[%0d]: got q=%0d rco=%0b load=%0b, expected q=6 rco=0 load=0",
                     i, Q, RCO, LOAD);
         end
      end
   endtask

   // Mode changes every edge with no idle cycles, starting from Q=6.
   task automatic test_back_to_back();
      logic [1:0] modo_v [7];
      logic [3:0] exp_q  [7];
      logic       exp_r  [7];
      logic       exp_l  [7];
      modo_v = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b11};
      exp_q  = '{4'd7, 4'd6, 4'd3, 4'd0, 4'd15, 4'd0, 4'd5};
      exp_r  = '{0, 0, 0, 0, 1, 1, 0};
      exp_l  = '{0, 0, 0, 0, 0, 0, 1};
      ENABLE = 1'b1;
      for (int i = 0; i < 7; i++) begin
         MODO = modo_v[i];
         D    = (i == 6) ? 4'd5 : 4'd12;
         tick();
         n_cmp++;
         if ({Q, RCO, LOAD} !== {exp_q[i], exp_r[i], exp_l[i]}) begin
            n_err++;
            $display("FAIL b2b[%0d]: got q=%0d rco=%0b load=%0b, expected q=%0d rco=%0b load=%0b",
                     i, Q, RCO, LOAD, exp_q[i], exp_r[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      // Drive a wrap so RCO is high, then reset must clear it at once.
      ENABLE = 1'b1;
      MODO   = 2'b11;
      D      = 4'd15;
      tick();
      MODO = 2'b00;
      tick();
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL mid_wrap: got q=%0d rco=%0b load=%0b, expected q=0 rco=1 load=0",
                  Q, RCO, LOAD);
      end
      // Pending load discarded by reset.
      MODO  = 2'b11;
      D     = 4'd9;
      RESET = 1'b1;
      #1;
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL mid_async: got q=%0d rco=%0b load=%0b, expected q=0 rco=0 load=0",
                  Q, RCO, LOAD);
      end
      tick();
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL mid_load_dropped: got q=%0d rco=%0b load=%0b, expected q=0 rco=0 load=0",
                  Q, RCO, LOAD);
      end
      RESET = 1'b0;
      MODO  = 2'b00;
      tick();
      n_cmp++;
      if ({Q, RCO, LOAD} !== {4'd1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL mid_resume: got q=%0d rco=%0b load=%0b, expected q=1 rco=0 load=0",
                  Q, RCO, LOAD);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_up_count();
      test_down_count();
      test_down3_count();
      test_load();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
